// File: rtl/word_serializer.sv
// word_serializer: captures a WIDTH-bit word and shifts it out LSB first over a
// valid/ready link, one bit per accepted transfer. load is gated until the word
// has fully drained; done pulses for one cycle after the final transfer.
// Optional feature macro: WORD_SERIALIZER_PARITY_EN appends an even-parity bit
// (XOR of the captured word) as an extra final transfer.
module word_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef WORD_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t         state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;
  logic             xfer;
  logic             last_bit;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic             par;
`endif

  // A transfer needs a valid bit; valid is simply "not idle".
  assign xfer     = (state != IDLE) & out_ready;
  assign last_bit = (count == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and link outputs; out defaults to the shift register LSB,
  // which is zero after drain because the register zero-fills from the MSB.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out        = sreg[0];
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
        if (xfer && last_bit) state_nxt = PARITY;
`else
        out_last = last_bit;
        if (xfer && last_bit) state_nxt = IDLE;
`endif
      end
`ifdef WORD_SERIALIZER_PARITY_EN
      PARITY: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out       = par;
        if (xfer) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accepted load, shift right on each data transfer,
  // and pulse done in the cycle after the word's final transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg  <= '0;
      count <= '0;
      done  <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= xfer && (state_nxt == IDLE);
      if (state == IDLE && load) begin
        sreg  <= in;
        count <= '0;
`ifdef WORD_SERIALIZER_PARITY_EN
        par   <= ^in;
`endif
      end else if (state == SHIFT && xfer) begin
        sreg  <= sreg >> 1;
        count <= count + CW'(1);
      end
    end
  end
endmodule
